// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier round-robin scheduler.
// No ports. The typedefs describe the default 4-requester / 4-bit configuration.
// The wrap_inc helper provides modulo stepping for the arbiter search.
package mult_sched_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATAWIDTH_DEF = 4;
    localparam int ID_W          = $clog2(NUM_REQ_DEF);

    typedef logic [ID_W-1:0]            req_id_t;
    typedef logic [2*DATAWIDTH_DEF-1:0] product_t;

    // Increment v and wrap it modulo n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. This is purely combinational logic.
// The search starts one past ptr and wraps modulo N.
//   req    in  N   request lines
//   en     in  1   grant enable (credit available)
//   ptr    in  IW  index of the last granted requester
//   gnt    out N   one-hot grant, or zero when disabled or idle
//   gnt_id out IW  index of the granted requester (0 when gnt is zero)
module rr_arbiter
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);
    import mult_sched_pkg::*;

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 32'(ptr);
        for (int k = 0; k < N; k++) begin
            idx = wrap_inc(idx, N);
            if (en && !found && req[IW'(idx)]) begin
                found           = 1'b1;
                gnt[IW'(idx)]   = 1'b1;
                gnt_id          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one in-order pipelined multiplier among NUM_REQ requesters.
// Arbitration is round-robin. Each issued request pushes its requester ID into a tag FIFO.
// Each returning product pops the FIFO to find which requester receives it.
//   clk, rst              clock, asynchronous active-low reset
//   req_valid/ready/a/b   per-requester request handshake; operand slices are packed
//   mul_i_valid/a/b       issue side of the multiplier
//   mul_o_valid/z         return side of the multiplier
//   rsp_valid/id/z        one-hot result strobe with its ID and product
//   outstanding           number of operations in flight
//   err_underflow         sticky flag: a result returned while no tag was pending
module mult_rr_scheduler
#(
    parameter int NUM_REQ         = 4,
    parameter int DATAWIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]           req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]           req_b,
    output logic                                   mul_i_valid,
    output logic [DATAWIDTH-1:0]                   mul_a,
    output logic [DATAWIDTH-1:0]                   mul_b,
    input  logic                                   mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]                 mul_z,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [ID_W-1:0]                        rsp_id,
    output logic [2*DATAWIDTH-1:0]                 rsp_z,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_underflow
);
    import mult_sched_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PW    = 2 * DATAWIDTH;

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 mul_v_q, mul_v_d;
    logic [DATAWIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [PW-1:0]        rsp_z_q, rsp_z_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [ID_W-1:0]      tag_q [MAX_OUTSTANDING];

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 can_issue, push, pop;
    logic [DATAWIDTH-1:0] sel_a, sel_b;
    logic [ID_W-1:0]      head_id;

    // A return in the current cycle does not free a credit until the next cycle.
    assign can_issue = (cnt_q < CNT_W'(MAX_OUTSTANDING));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req_valid),
        .en     (can_issue),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    // gnt is only set on bits where req_valid is set, so any grant is a transfer.
    assign push      = |gnt;
    assign pop       = mul_o_valid && (cnt_q != '0);
    assign head_id   = tag_q[rd_q];

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*DATAWIDTH +: DATAWIDTH];
                sel_b = req_b[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        mul_v_d     = push;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        cnt_d       = cnt_q;
        err_d       = err_q | (mul_o_valid && (cnt_q == '0));

        if (push) begin
            ptr_d   = gnt_id;
            mul_a_d = sel_a;
            mul_b_d = sel_b;
            wr_d    = (wr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
        end

        if (pop) begin
            rsp_valid_d[head_id] = 1'b1;
            rsp_id_d             = head_id;
            rsp_z_d              = mul_z;
            rd_d                 = (rd_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            mul_v_q     <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_v_q     <= mul_v_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            if (push) begin
                tag_q[wr_q] <= gnt_id;
            end
        end
    end

    assign mul_i_valid   = mul_v_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_z         = rsp_z_q;
    assign outstanding   = cnt_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler (NUM_REQ=4, DATAWIDTH=4, MAX_OUTSTANDING=4).
// The bench supplies a two-stage multiplier, so L=2. A manual override lets the
// bench hold the multiplier idle or inject returns.
module tb_mult_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        mul_i_valid;
    logic [3:0]  mul_a, mul_b;
    logic        mul_o_valid;
    logic [7:0]  mul_z;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_z;
    logic [2:0]  outstanding;
    logic        err_underflow;

    logic        man = 1'b1;
    logic        man_v = 1'b0;
    logic [7:0]  man_z = '0;
    logic        mdl_flush = 1'b0;
    logic [1:0]  pv = '0;
    logic [7:0]  pz0 = '0, pz1 = '0;

    int n_pass = 0;
    int n_total = 0;
    int exp_q[$];
    int e;
    int got;

    mult_rr_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .mul_i_valid   (mul_i_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_o_valid   (mul_o_valid),
        .mul_z         (mul_z),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_z         (rsp_z),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mdl_flush) pv <= '0;
        else           pv <= {pv[0], mul_i_valid};
        pz0 <= {4'b0, mul_a} * {4'b0, mul_b};
        pz1 <= pz0;
    end

    assign mul_o_valid = man ? man_v : pv[1];
    assign mul_z       = man ? man_z : pz1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_mul_i_valid", 32'(mul_i_valid), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_z", 32'(rsp_z), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err_underflow), 0);
        chk("rst_ready", 32'(req_ready), 0);
        tick(); tick();
        rst = 1'b1;
        man = 1'b0;
        tick();

        // Single request from requester 2: A=3, B=5.
        req_a = 16'h0300; req_b = 16'h0500; req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("single_mul_v", 32'(mul_i_valid), 1);
        chk("single_mul_a", 32'(mul_a), 3);
        chk("single_mul_b", 32'(mul_b), 5);
        chk("single_outst", 32'(outstanding), 1);
        tick(); #1 chk("single_no_rsp1", 32'(rsp_valid), 0);
        tick(); #1 chk("single_no_rsp2", 32'(rsp_valid), 0);
        tick(); #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_id", 32'(rsp_id), 2);
        chk("single_rsp_z", 32'(rsp_z), 15);
        chk("single_outst0", 32'(outstanding), 0);
        tick(); #1;
        chk("single_rsp_drop", 32'(rsp_valid), 0);
        chk("single_rsp_hold", 32'(rsp_z), 15);

        // Fairness: all valid, A=i+1, B=2. Last grant was 2, so the order is 3,0,1,2,...
        req_a = 16'h4321; req_b = 16'h2222; req_valid = 4'hF;
        got = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) req_valid = '0;
            #1;
            if (k < 8) begin
                chk("fair_grant", 32'(req_ready), 32'(1) << ((3 + k) % 4));
                exp_q.push_back((3 + k) % 4);
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("fair_extra_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("fair_rsp_valid", 32'(rsp_valid), 32'(1) << e);
                    chk("fair_rsp_id", 32'(rsp_id), 32'(e));
                    chk("fair_rsp_z", 32'(rsp_z), 32'(2 * (e + 1)));
                    got++;
                end
            end
            tick();
        end
        chk("fair_count", 32'(got), 8);
        chk("fair_outst0", 32'(outstanding), 0);

        // Credit stall: the multiplier is held idle and returns are injected by hand.
        man = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("credit_grant", 32'(req_ready), 1);
            chk("credit_outst", 32'(outstanding), 32'(k));
            tick();
        end
        #1;
        chk("credit_stall_ready", 32'(req_ready), 0);
        chk("credit_full", 32'(outstanding), 4);
        tick(); #1;
        chk("credit_stall_ready2", 32'(req_ready), 0);
        chk("credit_full2", 32'(outstanding), 4);
        man_v = 1'b1; man_z = 8'h42;
        #1 chk("credit_same_cycle", 32'(req_ready), 0);
        tick();
        man_v = 1'b0;
        #1;
        chk("credit_ret_valid", 32'(rsp_valid), 1);
        chk("credit_ret_z", 32'(rsp_z), 32'h42);
        chk("credit_ret_outst", 32'(outstanding), 3);
        chk("credit_resume", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        #1 chk("credit_refull", 32'(outstanding), 4);
        for (int j = 0; j < 4; j++) begin
            man_v = 1'b1; man_z = 8'(j + 1);
            tick();
            man_v = 1'b0;
            #1;
            chk("drain_rsp_valid", 32'(rsp_valid), 1);
            chk("drain_rsp_z", 32'(rsp_z), 32'(j + 1));
            chk("drain_outst", 32'(outstanding), 32'(3 - j));
        end
        for (int j = 0; j < 10; j++) tick();
        man = 1'b0;

        // Streaming from requester 1 with 15*15. The FIFO pointers wrap several times.
        req_a = 16'h00F0; req_b = 16'h00F0; req_valid = 4'b0010;
        got = 0;
        for (int k = 0; k < 24; k++) begin
            if (k == 16) req_valid = '0;
            #1;
            if (k < 16) begin
                chk("stream_ready", 32'(req_ready), 32'h2);
                chk("stream_outst", 32'(outstanding), 32'((k < 3) ? k : 3));
            end
            if (rsp_valid != '0) begin
                chk("stream_rsp_valid", 32'(rsp_valid), 32'h2);
                chk("stream_rsp_z", 32'(rsp_z), 225);
                got++;
            end
            tick();
        end
        chk("stream_count", 32'(got), 16);
        chk("stream_outst0", 32'(outstanding), 0);

        // Underflow after reset.
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        man = 1'b1; man_v = 1'b1; man_z = 8'hAA;
        tick();
        man_v = 1'b0;
        #1;
        chk("uf_rsp_valid", 32'(rsp_valid), 0);
        chk("uf_rsp_z", 32'(rsp_z), 0);
        chk("uf_err", 32'(err_underflow), 1);
        chk("uf_outst", 32'(outstanding), 0);
        tick(); tick(); tick();
        #1 chk("uf_err_sticky", 32'(err_underflow), 1);
        man = 1'b0;

        // Reset with two operations in flight.
        req_a = 16'h0005; req_b = 16'h0003; req_valid = 4'b0001;
        #1 chk("mid_grant", 32'(req_ready), 1);
        tick(); tick();
        req_valid = '0;
        #1 chk("mid_outst2", 32'(outstanding), 2);
        chk("mid_mul_a", 32'(mul_a), 5);
        rst = 1'b0; mdl_flush = 1'b1;
        #1;
        chk("mid_rst_mul_v", 32'(mul_i_valid), 0);
        chk("mid_rst_mul_a", 32'(mul_a), 0);
        chk("mid_rst_mul_b", 32'(mul_b), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 0);
        chk("mid_rst_outst", 32'(outstanding), 0);
        chk("mid_rst_err", 32'(err_underflow), 0);
        tick(); tick();
        rst = 1'b1; mdl_flush = 1'b0;
        req_a = 16'h4321; req_b = 16'h2222; req_valid = 4'hF;
        #1 chk("post_rst_grant0", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        #1;
        chk("post_mul_v", 32'(mul_i_valid), 1);
        chk("post_mul_a", 32'(mul_a), 1);
        tick(); tick(); tick();
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 1);
        chk("post_rsp_z", 32'(rsp_z), 2);
        chk("post_err", 32'(err_underflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
